// File: rtl/mem_arb_if.sv
// mem_arb_if: requester-side and memory-side signals of the data-memory arbiter.
// Latency: none, wires only.
// Backpressure: requesters hold req until their ack; the memory side never stalls.
interface mem_arb_if #(
   parameter int HBIT_ADDR = 15,
   parameter int HBIT_DATA = 15
);
   logic               iw_req0;
   logic [HBIT_ADDR:0] iw_addr0;
   logic               iw_req1;
   logic               iw_we1;
   logic [HBIT_ADDR:0] iw_addr1;
   logic [HBIT_DATA:0] iw_wdata1;
   logic               ow_ack0;
   logic               ow_ack1;
   logic [HBIT_DATA:0] ow_rdata;
   logic               ow_mem_en;
   logic               ow_mem_we;
   logic [HBIT_ADDR:0] ow_mem_addr;
   logic [HBIT_DATA:0] ow_mem_wdata;
   logic [HBIT_DATA:0] iw_mem_rdata;
   logic               ow_busy;

   // arbiter side
   modport slave (
      input  iw_req0, iw_addr0, iw_req1, iw_we1, iw_addr1, iw_wdata1, iw_mem_rdata,
      output ow_ack0, ow_ack1, ow_rdata, ow_mem_en, ow_mem_we, ow_mem_addr,
             ow_mem_wdata, ow_busy
   );

   // requesters plus memory macro side
   modport master (
      output iw_req0, iw_addr0, iw_req1, iw_we1, iw_addr1, iw_wdata1, iw_mem_rdata,
      input  ow_ack0, ow_ack1, ow_rdata, ow_mem_en, ow_mem_we, ow_mem_addr,
             ow_mem_wdata, ow_busy
   );
endinterface

// File: rtl/mem_arb.sv
// mem_arb: shares one data-memory port between fetch (req0) and memory stage (req1).
// Latency: store acked 2 cycles after the grant-sampling cycle, load 2+RD_LAT; one outstanding.
// Backpressure: requests are held until ack; losers and requests arriving while busy wait.
// Build option MEM_ARB_PRIO_MO_EN: fixed priority, req1 wins ties, no round-robin pointer.
module mem_arb #(
   parameter int RD_LAT    = 2,
   parameter int HBIT_ADDR = 15,
   parameter int HBIT_DATA = 15
) (
   input  logic     iw_clk,
   input  logic     iw_rst,
   mem_arb_if.slave bus
);
   typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_ACK} state_t;

   // remaining S_WAIT cycles after the issue cycle; RD_LAT is limited to 1..7
   localparam logic [2:0] WAIT_INIT = 3'(RD_LAT - 1);

   state_t             state, state_nxt;
   logic [2:0]         wait_cnt, wait_cnt_nxt;
   logic               gnt_id;
   logic               lat_we;
   logic [HBIT_ADDR:0] lat_addr;
   logic [HBIT_DATA:0] lat_wdata;
   logic [HBIT_DATA:0] rdata_q;
   logic               any_req;
   logic               grant;
   logic               pick1;

   assign any_req = bus.iw_req0 | bus.iw_req1;
   assign grant   = (state == S_IDLE) & any_req;

`ifdef MEM_ARB_PRIO_MO_EN
   assign pick1 = bus.iw_req1;
`else
   // rr_ptr names the requester that wins the next tie; it starts at fetch and,
   // after every grant, points at the requester that was not just served
   logic rr_ptr;

   assign pick1 = bus.iw_req1 & (~bus.iw_req0 | rr_ptr);

   // advance tie preference on every grant
   always_ff @(posedge iw_clk or posedge iw_rst) begin
      if (iw_rst)     rr_ptr <= 1'b0;
      else if (grant) rr_ptr <= ~pick1;
   end
`endif

   // state and wait counter registers
   always_ff @(posedge iw_clk or posedge iw_rst) begin
      if (iw_rst) begin
         state    <= S_IDLE;
         wait_cnt <= 3'd0;
      end else begin
         state    <= state_nxt;
         wait_cnt <= wait_cnt_nxt;
      end
   end

   // next state: idle -> issue -> (wait) -> ack -> idle
   always_comb begin
      state_nxt    = state;
      wait_cnt_nxt = wait_cnt;
      case (state)
         S_IDLE:  if (any_req) state_nxt = S_ISSUE;
         S_ISSUE: begin
            if (lat_we) begin
               state_nxt = S_ACK;
            end else begin
               state_nxt    = S_WAIT;
               wait_cnt_nxt = WAIT_INIT;
            end
         end
         S_WAIT: begin
            if (wait_cnt == 3'd0) state_nxt = S_ACK;
            else                  wait_cnt_nxt = wait_cnt - 3'd1;
         end
         S_ACK:   state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   // latch the winner's command at grant; later input changes are ignored
   always_ff @(posedge iw_clk or posedge iw_rst) begin
      if (iw_rst) begin
         gnt_id    <= 1'b0;
         lat_we    <= 1'b0;
         lat_addr  <= '0;
         lat_wdata <= '0;
      end else if (grant) begin
         gnt_id    <= pick1;
         lat_we    <= pick1 & bus.iw_we1;
         lat_addr  <= pick1 ? bus.iw_addr1 : bus.iw_addr0;
         lat_wdata <= pick1 ? bus.iw_wdata1 : '0;
      end
   end

   // read data captured on the last wait cycle, cleared by a write
   always_ff @(posedge iw_clk or posedge iw_rst) begin
      if (iw_rst)                                   rdata_q <= '0;
      else if (state == S_WAIT && wait_cnt == 3'd0) rdata_q <= bus.iw_mem_rdata;
      else if (state == S_ISSUE && lat_we)          rdata_q <= '0;
   end

   // memory-side fields are gated to the issue cycle so they are 0 otherwise
   assign bus.ow_mem_en    = (state == S_ISSUE);
   assign bus.ow_mem_we    = (state == S_ISSUE) & lat_we;
   assign bus.ow_mem_addr  = (state == S_ISSUE) ? lat_addr : '0;
   assign bus.ow_mem_wdata = (state == S_ISSUE) ? lat_wdata : '0;
   assign bus.ow_ack0      = (state == S_ACK) & ~gnt_id;
   assign bus.ow_ack1      = (state == S_ACK) & gnt_id;
   assign bus.ow_rdata     = rdata_q;
   assign bus.ow_busy      = (state != S_IDLE);
endmodule
